// File: rtl/calc_seq_ctrl_if.sv
// Operand/opcode strobes, ALU operand/enable/result lines and status of the calculator sequencer.
// The environment (stimulus + ALU) is the master; calc_seq_ctrl is the slave.
interface calc_seq_ctrl_if;
  logic        num_valid;
  logic [7:0]  num_in;
  logic        op_valid;
  logic [1:0]  op_in;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        enable_add;
  logic        enable_sub;
  logic        enable_mul;
  logic        enable_div;
  logic [8:0]  result_add;
  logic [7:0]  result_sub;
  logic [15:0] result_mul;
  logic [7:0]  result_div;
  logic        alu_error;
  logic [15:0] result;
  logic        result_valid;
  logic        error_flag;
  logic [2:0]  state;

  modport slave (
    input  num_valid, num_in, op_valid, op_in,
    input  result_add, result_sub, result_mul, result_div, alu_error,
    output alu_a, alu_b, enable_add, enable_sub, enable_mul, enable_div,
    output result, result_valid, error_flag, state
  );

  modport master (
    output num_valid, num_in, op_valid, op_in,
    output result_add, result_sub, result_mul, result_div, alu_error,
    input  alu_a, alu_b, enable_add, enable_sub, enable_mul, enable_div,
    input  result, result_valid, error_flag, state
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Operand/opcode sequencer for an external 8-bit ALU; latches the selected result after one EXEC cycle.
// Optional macro CALC_CHAIN_EN: an opcode strobe in DONE reuses result[7:0] as the next A operand.
//
// state  | code | meaning
// IDLE   | 0    | waiting for operand A
// GET_OP | 1    | waiting for opcode
// GET_B  | 2    | waiting for operand B
// EXEC   | 3    | one enable asserted, ALU result sampled on exit
// DONE   | 4    | result valid, holding
// ERR    | 5    | divide error, held until clear/reset
module calc_seq_ctrl (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  calc_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_OP = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [1:0] OP_DIV = 2'd3;

  state_t      st;
  logic [1:0]  opcode;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  en_q;
  logic [15:0] result_q;
  logic        valid_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st       <= IDLE;
      opcode   <= 2'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      en_q     <= 4'd0;
      result_q <= 16'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_q <= 4'd0;
      case (st)
        IDLE: begin
          if (bus.num_valid) begin
            a_q <= bus.num_in;
            st  <= GET_OP;
          end
        end
        GET_OP: begin
          if (bus.op_valid) begin
            opcode <= bus.op_in;
            st     <= GET_B;
          end
        end
        GET_B: begin
          if (bus.num_valid) begin
            b_q  <= bus.num_in;
            en_q <= 4'b0001 << opcode;
            st   <= EXEC;
          end
        end
        EXEC: begin
          // alu_error only means something for a divide
          if (opcode == OP_DIV && bus.alu_error) begin
            result_q <= 16'd0;
            err_q    <= 1'b1;
            st       <= ERR;
          end else begin
            case (opcode)
              2'd0:    result_q <= {7'd0, bus.result_add};
              2'd1:    result_q <= {8'd0, bus.result_sub};
              2'd2:    result_q <= bus.result_mul;
              default: result_q <= {8'd0, bus.result_div};
            endcase
            valid_q <= 1'b1;
            st      <= DONE;
          end
        end
        DONE: begin
          if (bus.num_valid) begin
            a_q     <= bus.num_in;
            valid_q <= 1'b0;
            st      <= GET_OP;
          end
`ifdef CALC_CHAIN_EN
          else if (bus.op_valid) begin
            a_q     <= result_q[7:0];
            opcode  <= bus.op_in;
            valid_q <= 1'b0;
            st      <= GET_B;
          end
`else
`endif
        end
        ERR: begin
          st <= ERR;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.enable_add   = en_q[0];
  assign bus.enable_sub   = en_q[1];
  assign bus.enable_mul   = en_q[2];
  assign bus.enable_div   = en_q[3];
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.error_flag   = err_q;
  assign bus.state        = st;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: stimulus pushes arithmetic expectations, a monitor pops on each new result/error.
module tb_calc_seq_ctrl;

  logic clk;
  logic reset;
  logic clear;

  calc_seq_ctrl_if bus ();

  calc_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU driven from the registered operands
  assign bus.result_add = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.result_sub = bus.alu_a - bus.alu_b;
  assign bus.result_mul = {8'd0, bus.alu_a} * {8'd0, bus.alu_b};
  assign bus.result_div = (bus.alu_b != 8'd0) ? bus.alu_a / bus.alu_b : 8'd0;
  assign bus.alu_error  = (bus.alu_b == 8'd0);

  typedef struct {
    int r;
    bit e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model(input int a, input int op, input int b, output int r, output bit e);
    e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = (a - b + 256) % 256;
      2: r = a * b;
      default: begin
        if (b == 0) begin
          e = 1'b1;
          r = 0;
        end else begin
          r = a / b;
        end
      end
    endcase
  endfunction

  // monitor
  bit prev_rv = 1'b0;
  bit prev_ef = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if ((bus.result_valid && !prev_rv) || (bus.error_flag && !prev_ef)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 1, 0);
      end else begin
        x = sb.pop_front();
        chk("sb_result", int'(bus.result), x.r);
        chk("sb_error_flag", int'(bus.error_flag), int'(x.e));
        chk("sb_state", int'(bus.state), x.e ? 5 : 4);
      end
    end
    prev_rv = bus.result_valid;
    prev_ef = bus.error_flag;
  end

  function automatic int enables();
    return int'({bus.enable_div, bus.enable_mul, bus.enable_sub, bus.enable_add});
  endfunction

  // all strobes start on a falling edge and end on the next one
  task automatic strobe_num(input int v);
    bus.num_valid = 1'b1;
    bus.num_in    = v[7:0];
    @(negedge clk);
    bus.num_valid = 1'b0;
  endtask

  task automatic strobe_op(input int v);
    bus.op_valid = 1'b1;
    bus.op_in    = v[1:0];
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_alu_a"}, int'(bus.alu_a), 0);
    chk({tag, "_alu_b"}, int'(bus.alu_b), 0);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
    chk({tag, "_error_flag"}, int'(bus.error_flag), 0);
    chk({tag, "_enables"}, enables(), 0);
  endtask

  task automatic do_calc(input int a, input int op, input int b);
    int r;
    bit e;
    model(a, op, b, r, e);
    sb.push_back('{r: r, e: e});
    strobe_num(a);
    chk("get_op_state", int'(bus.state), 1);
    strobe_op(op);
    chk("get_b_state", int'(bus.state), 2);
    strobe_num(b);
    chk("exec_state", int'(bus.state), 3);
    chk("exec_enable", enables(), 1 << op);
    chk("exec_alu_a", int'(bus.alu_a), a);
    chk("exec_alu_b", int'(bus.alu_b), b);
    @(negedge clk);
    chk("latency_out", int'(bus.result_valid | bus.error_flag), 1);
    chk("post_exec_enables", enables(), 0);
    if (e) begin
      bus.num_valid = 1'b1;
      bus.op_valid  = 1'b1;
      bus.num_in    = 8'd99;
      @(negedge clk);
      bus.num_valid = 1'b0;
      bus.op_valid  = 1'b0;
      chk("err_hold_state", int'(bus.state), 5);
      chk("err_hold_flag", int'(bus.error_flag), 1);
      chk("err_hold_result", int'(bus.result), 0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_zeroed("err_clear");
    end
  endtask

  initial begin
    int a;
    int op;
    int b;
    reset         = 1'b1;
    clear         = 1'b0;
    bus.num_valid = 1'b0;
    bus.num_in    = 8'd0;
    bus.op_valid  = 1'b0;
    bus.op_in     = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zeroed("reset");

    do_calc(15, 0, 10);
    do_calc(200, 0, 55);
    do_calc(123, 0, 215);
    do_calc(200, 2, 55);
    do_calc(123, 1, 215);
    do_calc(100, 3, 27);
    do_calc(0, 3, 55);
    do_calc(123, 3, 0);
    do_calc(77, 0, 0);

    // clear in GET_B, racing a num strobe
    strobe_num(40);
    strobe_op(2);
    chk("abort_get_b_state", int'(bus.state), 2);
    clear         = 1'b1;
    bus.num_valid = 1'b1;
    bus.num_in    = 8'd77;
    @(negedge clk);
    clear         = 1'b0;
    bus.num_valid = 1'b0;
    check_zeroed("clear_get_b");

    // reset mid-EXEC after a completed result, with clear and strobes also high
    do_calc(9, 2, 9);
    strobe_num(50);
    strobe_op(0);
    strobe_num(60);
    chk("abort_exec_state", int'(bus.state), 3);
    reset         = 1'b1;
    clear         = 1'b1;
    bus.num_valid = 1'b1;
    bus.op_valid  = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    clear         = 1'b0;
    bus.num_valid = 1'b0;
    bus.op_valid  = 1'b0;
    check_zeroed("reset_exec");

    do_calc(15, 0, 10);
`ifdef CALC_CHAIN_EN
    begin
      int r;
      bit e;
      model(25, 2, 3, r, e);
      sb.push_back('{r: r, e: e});
      strobe_op(2);
      chk("chain_state", int'(bus.state), 2);
      chk("chain_alu_a", int'(bus.alu_a), 25);
      chk("chain_result_valid", int'(bus.result_valid), 0);
      strobe_num(3);
      chk("chain_enable", enables(), 4);
      @(negedge clk);
      chk("chain_result", int'(bus.result), 75);
    end
`else
    strobe_op(2);
    chk("nochain_state", int'(bus.state), 4);
    chk("nochain_result", int'(bus.result), 25);
    chk("nochain_result_valid", int'(bus.result_valid), 1);
`endif

    for (int i = 0; i < 40; i++) begin
      a  = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 3));
      b  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      do_calc(a, op, b);
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
